// File: rtl/pkg_tpu.sv
// rtl/pkg_tpu.sv - shared TPU types used by the load/store stream port
// Purpose: data and address element types plus the load/store channel FSM
// state encoding shared by the lane-side stream ports.
package pkg_tpu;

  typedef logic [31:0] data_t;
  typedef logic [15:0] address_t;

  // Store channel uses IDLE/REQ/XFER/DONE; DRAIN is load-only.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ldst_fsm_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO used for store and load element buffering
// Ports:
//   clock, reset      : clock, synchronous active-high reset (flushes pointers/count)
//   push, din         : write request and data; a push while full is dropped
//   pop, dout         : read request and head data; a pop while empty is ignored
//   full, empty, count: occupancy status (count is 0..DEPTH)
// dout reads as zero while empty so a flushed FIFO presents a clean head.
module sync_fifo #(
  parameter int  DEPTH  = 8,
  parameter type data_t = logic [31:0]
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  data_t                    din,
  input  logic                     pop,
  output data_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  data_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Full is judged on the registered count, so a push that meets a pop in the
  // same cycle is still dropped when the FIFO was full.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ldst_stream_port.sv
// rtl/ldst_stream_port.sv - lane-side load/store stream port in front of a DMem port pair
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   I_St_Cmd, I_St_Length/Stride/Base  : store stream start pulse and config
//   I_Lane_St_Push/Data, O_Lane_St_Full: lane store data into the store FIFO
//   O_St_Busy, O_St_Done               : store channel active / completion pulse
//   I_Ld_Cmd, I_Ld_Length/Stride/Base  : load stream start pulse and config
//   O_Lane_Ld_Vld/Data, I_Lane_Ld_Pop  : load FIFO head towards the lane
//   O_Ld_Busy, O_Ld_Done               : load channel active / completion pulse
//   O_St_* / I_St_Grant/Ready          : DMem store request/handshake and data
//   O_Ld_* / I_Ld_Grant/Ready/Data     : DMem load request/handshake and return data
module ldst_stream_port
  import pkg_tpu::*;
#(
  parameter int ST_DEPTH = 8,
  parameter int LD_DEPTH = 8
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     I_St_Cmd,
  input  address_t I_St_Length,
  input  address_t I_St_Stride,
  input  address_t I_St_Base,
  input  logic     I_Lane_St_Push,
  input  data_t    I_Lane_St_Data,
  output logic     O_Lane_St_Full,
  output logic     O_St_Busy,
  output logic     O_St_Done,
  input  logic     I_Ld_Cmd,
  input  address_t I_Ld_Length,
  input  address_t I_Ld_Stride,
  input  address_t I_Ld_Base,
  output logic     O_Lane_Ld_Vld,
  output data_t    O_Lane_Ld_Data,
  input  logic     I_Lane_Ld_Pop,
  output logic     O_Ld_Busy,
  output logic     O_Ld_Done,
  output logic     O_St_Req,
  output address_t O_St_Length,
  output address_t O_St_Stride,
  output address_t O_St_Base_Addr,
  output logic     O_St_Valid,
  output data_t    O_St_Data,
  input  logic     I_St_Grant,
  input  logic     I_St_Ready,
  output logic     O_Ld_Req,
  output address_t O_Ld_Length,
  output address_t O_Ld_Stride,
  output address_t O_Ld_Base_Addr,
  output logic     O_Ld_Valid,
  input  data_t    I_Ld_Data,
  input  logic     I_Ld_Grant,
  input  logic     I_Ld_Ready
);

  localparam int SCW = $clog2(ST_DEPTH) + 1;
  localparam int LCW = $clog2(LD_DEPTH) + 1;
  localparam logic [LCW:0] LD_CREDIT = (LCW + 1)'(LD_DEPTH);

  // ---------------- store channel ----------------
  ldst_fsm_t          st_state;
  address_t           st_len, st_stride, st_base, st_cnt;
  logic               st_zero_done;
  logic               st_full, st_empty, st_valid, st_busy;
  logic [SCW-1:0]     st_count_unused;

  sync_fifo #(.DEPTH(ST_DEPTH), .data_t(data_t)) u_st_fifo (
    .clock (clock),
    .reset (reset),
    .push  (I_Lane_St_Push),
    .din   (I_Lane_St_Data),
    .pop   (st_valid),
    .dout  (O_St_Data),
    .full  (st_full),
    .empty (st_empty),
    .count (st_count_unused)
  );

  assign st_busy    = (st_state != IDLE);
  assign st_valid   = (st_state == XFER) & I_St_Grant & I_St_Ready & ~st_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_state     <= IDLE;
      st_len       <= '0;
      st_stride    <= '0;
      st_base      <= '0;
      st_cnt       <= '0;
      st_zero_done <= 1'b0;
    end else begin
      st_zero_done <= 1'b0;
      case (st_state)
        IDLE: if (I_St_Cmd) begin
          st_len    <= I_St_Length;
          st_stride <= I_St_Stride;
          st_base   <= I_St_Base;
          st_cnt    <= '0;
          // A zero-length stream completes without ever requesting DMem.
          if (I_St_Length == '0) st_zero_done <= 1'b1;
          else                   st_state     <= REQ;
        end
        REQ:  if (I_St_Grant & I_St_Ready) st_state <= XFER;
        XFER: if (st_valid) begin
          st_cnt <= st_cnt + address_t'(1);
          if (st_cnt == st_len - address_t'(1)) st_state <= DONE;
        end
        default: st_state <= IDLE;
      endcase
    end
  end

  assign O_Lane_St_Full = st_full;
  assign O_St_Busy      = st_busy;
  assign O_St_Done      = (st_state == DONE) | st_zero_done;
  assign O_St_Req       = (st_state == REQ) | (st_state == XFER);
  assign O_St_Valid     = st_valid;
  assign O_St_Length    = st_busy ? st_len    : '0;
  assign O_St_Stride    = st_busy ? st_stride : '0;
  assign O_St_Base_Addr = st_busy ? st_base   : '0;

  // ---------------- load channel ----------------
  ldst_fsm_t          ld_state;
  address_t           ld_len, ld_stride, ld_base, ld_issued;
  logic               ld_zero_done, ld_inflight;
  logic               ld_empty, ld_valid, ld_busy, ld_credit_ok;
  logic               ld_full_unused;
  logic [LCW-1:0]     ld_count;

  sync_fifo #(.DEPTH(LD_DEPTH), .data_t(data_t)) u_ld_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ld_inflight),
    .din   (I_Ld_Data),
    .pop   (I_Lane_Ld_Pop),
    .dout  (O_Lane_Ld_Data),
    .full  (ld_full_unused),
    .empty (ld_empty),
    .count (ld_count)
  );

  // Buffered plus in-flight elements must leave room for the next return,
  // which keeps the load FIFO from ever overflowing.
  assign ld_credit_ok = ({1'b0, ld_count} + {{LCW{1'b0}}, ld_inflight}) < LD_CREDIT;
  assign ld_busy      = (ld_state != IDLE);
  assign ld_valid     = (ld_state == XFER) & I_Ld_Grant & I_Ld_Ready & ld_credit_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state     <= IDLE;
      ld_len       <= '0;
      ld_stride    <= '0;
      ld_base      <= '0;
      ld_issued    <= '0;
      ld_zero_done <= 1'b0;
      ld_inflight  <= 1'b0;
    end else begin
      ld_zero_done <= 1'b0;
      // DMem answers exactly one cycle after each issue.
      ld_inflight  <= ld_valid;
      case (ld_state)
        IDLE: if (I_Ld_Cmd) begin
          ld_len    <= I_Ld_Length;
          ld_stride <= I_Ld_Stride;
          ld_base   <= I_Ld_Base;
          ld_issued <= '0;
          if (I_Ld_Length == '0) ld_zero_done <= 1'b1;
          else                   ld_state     <= REQ;
        end
        REQ:  if (I_Ld_Grant & I_Ld_Ready) ld_state <= XFER;
        XFER: if (ld_valid) begin
          ld_issued <= ld_issued + address_t'(1);
          if (ld_issued == ld_len - address_t'(1)) ld_state <= DRAIN;
        end
        DRAIN: if (!ld_inflight) ld_state <= DONE;
        default: ld_state <= IDLE;
      endcase
    end
  end

  assign O_Lane_Ld_Vld  = ~ld_empty;
  assign O_Ld_Busy      = ld_busy;
  assign O_Ld_Done      = (ld_state == DONE) | ld_zero_done;
  assign O_Ld_Req       = (ld_state == REQ) | (ld_state == XFER) | (ld_state == DRAIN);
  assign O_Ld_Valid     = ld_valid;
  assign O_Ld_Length    = ld_busy ? ld_len    : '0;
  assign O_Ld_Stride    = ld_busy ? ld_stride : '0;
  assign O_Ld_Base_Addr = ld_busy ? ld_base   : '0;

endmodule

// File: tb/tb_ldst_stream_port.sv
// tb/tb_ldst_stream_port.sv - directed self-checking bench for ldst_stream_port
module tb_ldst_stream_port;
  import pkg_tpu::*;

  logic     clock, reset;
  logic     I_St_Cmd, I_Lane_St_Push, I_Ld_Cmd, I_Lane_Ld_Pop;
  address_t I_St_Length, I_St_Stride, I_St_Base;
  address_t I_Ld_Length, I_Ld_Stride, I_Ld_Base;
  data_t    I_Lane_St_Data, I_Ld_Data;
  logic     I_St_Grant, I_St_Ready, I_Ld_Grant, I_Ld_Ready;
  logic     O_Lane_St_Full, O_St_Busy, O_St_Done, O_Lane_Ld_Vld, O_Ld_Busy, O_Ld_Done;
  logic     O_St_Req, O_St_Valid, O_Ld_Req, O_Ld_Valid;
  data_t    O_Lane_Ld_Data, O_St_Data;
  address_t O_St_Length, O_St_Stride, O_St_Base_Addr;
  address_t O_Ld_Length, O_Ld_Stride, O_Ld_Base_Addr;

  ldst_stream_port #(.ST_DEPTH(8), .LD_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .I_St_Cmd(I_St_Cmd), .I_St_Length(I_St_Length), .I_St_Stride(I_St_Stride), .I_St_Base(I_St_Base),
    .I_Lane_St_Push(I_Lane_St_Push), .I_Lane_St_Data(I_Lane_St_Data), .O_Lane_St_Full(O_Lane_St_Full),
    .O_St_Busy(O_St_Busy), .O_St_Done(O_St_Done),
    .I_Ld_Cmd(I_Ld_Cmd), .I_Ld_Length(I_Ld_Length), .I_Ld_Stride(I_Ld_Stride), .I_Ld_Base(I_Ld_Base),
    .O_Lane_Ld_Vld(O_Lane_Ld_Vld), .O_Lane_Ld_Data(O_Lane_Ld_Data), .I_Lane_Ld_Pop(I_Lane_Ld_Pop),
    .O_Ld_Busy(O_Ld_Busy), .O_Ld_Done(O_Ld_Done),
    .O_St_Req(O_St_Req), .O_St_Length(O_St_Length), .O_St_Stride(O_St_Stride),
    .O_St_Base_Addr(O_St_Base_Addr), .O_St_Valid(O_St_Valid), .O_St_Data(O_St_Data),
    .I_St_Grant(I_St_Grant), .I_St_Ready(I_St_Ready),
    .O_Ld_Req(O_Ld_Req), .O_Ld_Length(O_Ld_Length), .O_Ld_Stride(O_Ld_Stride),
    .O_Ld_Base_Addr(O_Ld_Base_Addr), .O_Ld_Valid(O_Ld_Valid), .I_Ld_Data(I_Ld_Data),
    .I_Ld_Grant(I_Ld_Grant), .I_Ld_Ready(I_Ld_Ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_total, n_pass;
  int    st_valid_cnt, ld_valid_cnt, st_done_cnt, ld_done_cnt, done_req_bad, ld_sent;
  data_t st_seen[$];
  data_t ld_got[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_stats();
    st_valid_cnt = 0; ld_valid_cnt = 0; st_done_cnt = 0; ld_done_cnt = 0;
    done_req_bad = 0; ld_sent = 0;
    st_seen.delete(); ld_got.delete();
  endtask

  // One clock: observe handshake outputs just before the edge, then play the
  // DMem load-return role (data appears one cycle after each O_Ld_Valid).
  task automatic tick();
    logic lv;
    #1;
    lv = O_Ld_Valid;
    if (lv) ld_valid_cnt++;
    if (O_St_Valid) begin st_valid_cnt++; st_seen.push_back(O_St_Data); end
    if (O_St_Done) st_done_cnt++;
    if (O_Ld_Done) ld_done_cnt++;
    if ((O_St_Done && O_St_Req) || (O_Ld_Done && O_Ld_Req)) done_req_bad++;
    @(posedge clock);
    #1;
    if (lv) begin I_Ld_Data = 32'hA000_0000 + data_t'(ld_sent); ld_sent++; end
    else I_Ld_Data = 32'hDEAD_BEEF;
  endtask

  task automatic st_push(input data_t d);
    I_Lane_St_Push = 1'b1; I_Lane_St_Data = d; tick(); I_Lane_St_Push = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; clr_stats();
    reset = 1'b1;
    I_St_Cmd = 0; I_Ld_Cmd = 0; I_Lane_St_Push = 0; I_Lane_Ld_Pop = 0;
    I_St_Length = 0; I_St_Stride = 0; I_St_Base = 0;
    I_Ld_Length = 0; I_Ld_Stride = 0; I_Ld_Base = 0;
    I_Lane_St_Data = 0; I_Ld_Data = 0;
    I_St_Grant = 0; I_St_Ready = 0; I_Ld_Grant = 0; I_Ld_Ready = 0;
    tick(); tick();

    // Reset state
    chk("rst_st_busy", O_St_Busy, 0);
    chk("rst_ld_busy", O_Ld_Busy, 0);
    chk("rst_st_req", O_St_Req, 0);
    chk("rst_ld_req", O_Ld_Req, 0);
    chk("rst_st_full", O_Lane_St_Full, 0);
    chk("rst_ld_vld", O_Lane_Ld_Vld, 0);
    chk("rst_st_len", O_St_Length, 0);
    reset = 1'b0;
    tick();

    // Store of 4 pre-pushed elements
    clr_stats();
    st_push(32'h11); st_push(32'h22); st_push(32'h33); st_push(32'h44);
    I_St_Grant = 1; I_St_Ready = 1;
    I_St_Cmd = 1; I_St_Length = 4; I_St_Stride = 1; I_St_Base = 16'h0100;
    tick();
    I_St_Cmd = 0;
    chk("s1_busy", O_St_Busy, 1);
    chk("s1_req", O_St_Req, 1);
    chk("s1_len", O_St_Length, 4);
    chk("s1_base", O_St_Base_Addr, 16'h0100);
    repeat (10) tick();
    chk("s1_valid_cnt", st_valid_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s1_data%0d", i), (st_seen.size() > i) ? st_seen[i] : 32'hFFFF_FFFF, 32'h11 * (i + 1));
    chk("s1_done_cnt", st_done_cnt, 1);
    chk("s1_done_req", done_req_bad, 0);
    chk("s1_busy_end", O_St_Busy, 0);
    chk("s1_len_idle", O_St_Length, 0);

    // Load of 10 with credit limit 8
    clr_stats();
    I_Ld_Grant = 1; I_Ld_Ready = 1;
    I_Ld_Cmd = 1; I_Ld_Length = 10; I_Ld_Stride = 2; I_Ld_Base = 16'h0400;
    tick();
    I_Ld_Cmd = 0;
    chk("l_len", O_Ld_Length, 10);
    repeat (30) tick();
    chk("l_issue8", ld_valid_cnt, 8);
    chk("l_stalled", O_Ld_Valid, 0);
    chk("l_vld", O_Lane_Ld_Vld, 1);
    chk("l_head", O_Lane_Ld_Data, 32'hA000_0000);
    chk("l_req_held", O_Ld_Req, 1);
    for (int i = 0; i < 2; i++) begin
      I_Lane_Ld_Pop = 1; ld_got.push_back(O_Lane_Ld_Data); tick();
    end
    I_Lane_Ld_Pop = 0;
    repeat (10) tick();
    chk("l_issue10", ld_valid_cnt, 10);
    for (int i = 0; i < 30; i++) begin
      I_Lane_Ld_Pop = O_Lane_Ld_Vld;
      if (O_Lane_Ld_Vld) ld_got.push_back(O_Lane_Ld_Data);
      tick();
    end
    I_Lane_Ld_Pop = 0;
    chk("l_pop_total", ld_got.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("l_data%0d", i), (ld_got.size() > i) ? ld_got[i] : 32'hFFFF_FFFF, 32'hA000_0000 + i);
    chk("l_done_cnt", ld_done_cnt, 1);
    chk("l_done_req", done_req_bad, 0);
    chk("l_busy_end", O_Ld_Busy, 0);

    // Store with a 3-cycle grant gap
    clr_stats();
    for (int i = 1; i <= 6; i++) st_push(data_t'(i));
    I_St_Cmd = 1; I_St_Length = 6; I_St_Stride = 1; I_St_Base = 16'h0010;
    tick();
    I_St_Cmd = 0;
    tick(); tick(); tick();
    I_St_Grant = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("g_valid_gap%0d", i), O_St_Valid, 0);
      chk($sformatf("g_req_gap%0d", i), O_St_Req, 1);
      tick();
    end
    chk("g_valid_before", st_valid_cnt, 2);
    I_St_Grant = 1;
    repeat (12) tick();
    chk("g_valid_cnt", st_valid_cnt, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("g_data%0d", i), (st_seen.size() > i) ? st_seen[i] : 32'hFFFF_FFFF, i + 1);
    chk("g_done_cnt", st_done_cnt, 1);

    // Zero-length store and load
    clr_stats();
    I_St_Cmd = 1; I_St_Length = 0; I_Ld_Cmd = 1; I_Ld_Length = 0;
    #1;
    chk("z_st_req0", O_St_Req, 0);
    tick();
    I_St_Cmd = 0; I_Ld_Cmd = 0;
    chk("z_st_done", O_St_Done, 1);
    chk("z_ld_done", O_Ld_Done, 1);
    chk("z_st_req", O_St_Req, 0);
    chk("z_ld_req", O_Ld_Req, 0);
    chk("z_st_busy", O_St_Busy, 0);
    tick();
    chk("z_st_done_end", O_St_Done, 0);
    chk("z_ld_done_end", O_Ld_Done, 0);

    // Full store FIFO, push+pop, ignored second command
    clr_stats();
    I_St_Grant = 0;
    for (int i = 0; i < 8; i++) st_push(32'h80 + i);
    chk("f_full", O_Lane_St_Full, 1);
    I_St_Cmd = 1; I_St_Length = 8; I_St_Stride = 2; I_St_Base = 16'h0200;
    tick();
    I_St_Length = 3; I_St_Stride = 5; I_St_Base = 16'h0300;
    tick();
    I_St_Cmd = 0;
    chk("f_len_kept", O_St_Length, 8);
    chk("f_stride_kept", O_St_Stride, 2);
    chk("f_base_kept", O_St_Base_Addr, 16'h0200);
    I_St_Grant = 1;
    tick();
    I_Lane_St_Push = 1; I_Lane_St_Data = 32'hEE;
    #1;
    chk("f_pushpop_valid", O_St_Valid, 1);
    tick();
    I_Lane_St_Push = 0;
    chk("f_not_full", O_Lane_St_Full, 0);
    repeat (15) tick();
    chk("f_valid_cnt", st_valid_cnt, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("f_data%0d", i), (st_seen.size() > i) ? st_seen[i] : 32'hFFFF_FFFF, 32'h80 + i);
    chk("f_fifo_empty_head", O_St_Data, 0);
    chk("f_done_cnt", st_done_cnt, 1);

    // Reset mid-stream with 3 store entries buffered
    clr_stats();
    for (int i = 0; i < 5; i++) st_push(32'h50 + i);
    I_St_Cmd = 1; I_St_Length = 5; I_Ld_Cmd = 1; I_Ld_Length = 4;
    tick();
    I_St_Cmd = 0; I_Ld_Cmd = 0;
    tick(); tick(); tick();
    chk("r_st_busy_pre", O_St_Busy, 1);
    chk("r_st_valid_pre", st_valid_cnt, 2);
    reset = 1;
    tick();
    chk("r_st_busy", O_St_Busy, 0);
    chk("r_ld_busy", O_Ld_Busy, 0);
    chk("r_st_req", O_St_Req, 0);
    chk("r_ld_req", O_Ld_Req, 0);
    chk("r_st_valid", O_St_Valid, 0);
    chk("r_ld_valid", O_Ld_Valid, 0);
    chk("r_st_head", O_St_Data, 0);
    chk("r_ld_vld", O_Lane_Ld_Vld, 0);
    chk("r_st_done", O_St_Done, 0);
    reset = 0;
    tick();
    chk("r_st_done_after", O_St_Done, 0);
    chk("r_ld_done_after", O_Ld_Done, 0);
    chk("r_done_cnt", st_done_cnt + ld_done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ldst_stream_port.md
Name: ldst_stream_port

Overview:
- Lane-side load/store stream port sitting directly upstream of the data memory (DMem) block.
- Accepts one store command and one load command from the lane pipeline, each carrying length, stride and base.
- Drives DMem's request/grant/ready/valid handshake and buffers store data from the lane in a FIFO.
- Collects DMem's one-cycle-latency load data into a FIFO that the lane pops.
- One instance per DMem port pair (port 1 or port 2).

Parameters:
- ST_DEPTH, 8, store-data FIFO entries (power of 2, ≥2).
- LD_DEPTH, 8, load-data FIFO entries (power of 2, ≥2); also the bound on in-flight plus buffered loads.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- I_St_Cmd  in  1  start store stream (one-cycle pulse).
- I_St_Length/I_St_Stride/I_St_Base  in  address_t each  store stream config.
- I_Lane_St_Push  in  1  push I_Lane_St_Data into the store FIFO.
- I_Lane_St_Data  in  data_t  store element.
- O_Lane_St_Full  out  1  store FIFO full.
- O_St_Busy/O_St_Done  out  1 each  store FSM not IDLE / one-cycle completion pulse.
- I_Ld_Cmd  in  1  start load stream.
- I_Ld_Length/I_Ld_Stride/I_Ld_Base  in  address_t each  load stream config.
- O_Lane_Ld_Vld  out  1  load FIFO non-empty.
- O_Lane_Ld_Data  out  data_t  load FIFO head.
- I_Lane_Ld_Pop  in  1  pop the load FIFO.
- O_Ld_Busy/O_Ld_Done  out  1 each.
- O_St_Req  out  1  to DMem I_St_ReqN.
- O_St_Length/O_St_Stride/O_St_Base_Addr  out  address_t  latched config.
- O_St_Valid  out  1  store element valid.
- O_St_Data  out  data_t  store FIFO head.
- I_St_Grant/I_St_Ready  in  1 each  from DMem.
- O_Ld_Req  out  1.
- O_Ld_Length/O_Ld_Stride/O_Ld_Base_Addr  out  address_t.
- O_Ld_Valid  out  1  load element issue.
- I_Ld_Data  in  data_t.
- I_Ld_Grant/I_Ld_Ready  in  1 each.

Behaviour:
- Reset: both FSMs to IDLE; FIFOs empty; counters 0; config registers 0; all outputs 0 except O_Lane_St_Full=0.

Store FSM (IDLE, REQ, XFER, DONE):
- IDLE: I_St_Cmd latches length/stride/base and clears cnt.
  - Length==0 → O_St_Done pulses next cycle; FSM stays IDLE; no request.
  - Otherwise → REQ.
- REQ/XFER: O_St_Req=1.
- REQ → XFER when I_St_Grant & I_St_Ready.
- XFER: O_St_Valid = I_St_Grant & I_St_Ready & ~st_empty (combinational).
  - Each Valid pops the FIFO and increments cnt.
  - Valid with cnt==Length-1 → DONE.
- DONE: O_St_Req=0 and O_St_Done=1 for one cycle → IDLE.
- I_St_Cmd while Busy is ignored.
- Store FIFO:
  - A push when full is dropped, even if a pop happens in the same cycle.
  - Push+pop when not full keeps the count.
  - Data pushed before the command is allowed and is consumed in order.

Load FSM (IDLE, REQ, XFER, DRAIN, DONE):
- IDLE/REQ handling mirrors the store FSM.
- XFER: O_Ld_Valid = I_Ld_Grant & I_Ld_Ready & (ld_count + inflight < LD_DEPTH).
- DMem returns I_Ld_Data exactly one cycle after O_Ld_Valid.
  - inflight is a 1-bit register set by Valid.
  - The FIFO push occurs when inflight==1.
- Valid with issued==Length-1 → DRAIN.
- DRAIN: wait for inflight==0 → DONE.
- DONE: O_Ld_Req=0 and O_Ld_Done pulse → IDLE.
- Pop when empty is ignored; a lane pop frees credit in the same cycle for the next cycle's issue.
- Credit check guarantees the FIFO never overflows.

Common rules:
- Store and load channels are fully independent and may run simultaneously.
- O_*_Length/Stride/Base_Addr hold the latched config while not IDLE and are 0 in IDLE.
- Counters are address_t wide, compared unsigned.
- Grant loss mid-XFER (DMem re-arbitrates) stalls Valid; the FSM keeps Req high and resumes.
- Reset mid-stream aborts immediately: FIFOs flushed, Req dropped, no Done pulse.

Decomposition:
- pkg_tpu: add ldst_fsm_t enum (IDLE, REQ, XFER, DRAIN, DONE); reuse existing data_t and address_t.
- Sub-module sync_fifo (parameters DEPTH, type data_t), instantiated once for store and once for load.
  - Ports: clock, reset, push, din, pop, dout, full, empty, count.

Test Plan:
- Push 4 values 0x11..0x44 → store cmd Length=4 → Grant=Ready=1: 4 O_St_Valid cycles with data 0x11,0x22,0x33,0x44 in order; then O_St_Req=0 and O_St_Done for 1 cycle; Busy=0.
- Load cmd Length=10, LD_DEPTH=8, lane never pops: exactly 8 O_Ld_Valid pulses, FIFO holds 8. Pop 2 → 2 more issues. Pop all 10 → Done after the last return; data order matches I_Ld_Data.
- Drop I_St_Grant for 3 cycles mid-stream (Length=6): O_St_Valid=0, O_St_Req held 1 during the gap; resume; total Valid count = 6.
- Length=0 store and load commands: Done pulse next cycle; O_*_Req never asserted.
- Fill the store FIFO (8 pushes) then push+pop in the same cycle: the push is dropped and the count drops to 7. Second I_St_Cmd while Busy is ignored (config unchanged).
- Assert reset in XFER with 3 entries buffered: next cycle both FSMs IDLE, FIFOs empty, Req/Valid/Done=0.
